// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: clear-FSM states
// and the address-width derivation used by every file of the slice.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by SB_SET, released by a write to the same
// register, wiped one entry per cycle by the soft-clear sweep.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  bit ZERO_REG = 1,
    localparam int AW       = addr_width(NREGS)
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              set_en,
    input  logic [AW-1:0]     set_a,
    input  logic              rel3_en,
    input  logic [AW-1:0]     rel3_a,
    input  logic              rel4_en,
    input  logic [AW-1:0]     rel4_a,
    input  logic              wipe_en,
    input  logic [AW-1:0]     wipe_a,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rbusy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // NOTE: busy_nxt gets a full default first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        busy_nxt = busy;
        if (wipe_en) busy_nxt[wipe_a] = 1'b0;
        if (rel3_en) busy_nxt[rel3_a] = 1'b0;
        if (rel4_en) busy_nxt[rel4_a] = 1'b0;
        // A new reservation is applied last so it outranks a same-cycle release.
        if (set_en)  busy_nxt[set_a]  = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // values from before the edge, regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!CLR_N) busy <= '0;
        else        busy <= busy_nxt;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        assign rbusy[k] = busy[ra[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with optional write-to-read bypass,
// a pending-bit scoreboard and a sequenced one-register-per-cycle soft clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  bit ZERO_REG = 1,
    parameter  bit BYPASS   = 0,
    localparam int AW       = addr_width(NREGS)
) (
    input  logic                CLK,
    input  logic                CLR_N,
    input  logic                WE3,
    input  logic [AW-1:0]       A3,
    input  logic [XLEN-1:0]     WD3,
    input  logic                WE4,
    input  logic [AW-1:0]       A4,
    input  logic [XLEN-1:0]     WD4,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*XLEN-1:0] RD,
    output logic [NRD-1:0]      RBUSY,
    input  logic                SB_SET,
    input  logic [AW-1:0]       SB_A,
    input  logic                SCLR,
    output logic                CBUSY
);

    clr_state_e    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic          clearing;
    logic          we3_eff, we4_eff, set_eff;

    assign clearing = (state == CLEAR);
    assign CBUSY    = clearing;

    // All external updates are frozen while the sweep owns the array.
    assign we3_eff = WE3    && !clearing && !(ZERO_REG && A3   == '0);
    assign we4_eff = WE4    && !clearing && !(ZERO_REG && A4   == '0);
    assign set_eff = SB_SET && !clearing && !(ZERO_REG && SB_A == '0);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (SCLR) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == AW'(NREGS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    logic [XLEN-1:0] regs [NREGS];

    // NOTE: the array is reset entry by entry because a reset must zero every
    // register; that makes it flops rather than a RAM macro.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (clearing) begin
            regs[idx] <= '0;
        end else begin
            if (we3_eff) regs[A3] <= WD3;
            // Port 4 is assigned second so it wins a same-address collision.
            if (we4_eff) regs[A4] <= WD4;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;

        assign ra = RA[k*AW +: AW];

        always_comb begin
            data = regs[ra];
            if (BYPASS && we3_eff && A3 == ra) data = WD3;
            if (BYPASS && we4_eff && A4 == ra) data = WD4;
            if (ZERO_REG && ra == '0)          data = '0;
        end

        assign RD[k*XLEN +: XLEN] = data;
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .set_en  (set_eff),
        .set_a   (SB_A),
        .rel3_en (we3_eff),
        .rel3_a  (A3),
        .rel4_en (we4_eff),
        .rel4_a  (A4),
        .wipe_en (clearing),
        .wipe_a  (idx),
        .ra      (RA),
        .rbusy   (RBUSY)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against two instances (BYPASS 0/1).
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    localparam int SEL_RD0    = 0;
    localparam int SEL_RD1    = 1;
    localparam int SEL_RB0    = 2;
    localparam int SEL_RB1    = 3;
    localparam int SEL_CBUSY  = 4;
    localparam int SEL_BP_RD0 = 5;

    logic                CLK = 1'b0;
    logic                CLR_N;
    logic                WE3, WE4, SB_SET, SCLR;
    logic [AW-1:0]       A3, A4, SB_A;
    logic [XLEN-1:0]     WD3, WD4;
    logic [NRD*AW-1:0]   RA;
    logic [NRD*XLEN-1:0] RD, RD_BP;
    logic [NRD-1:0]      RBUSY, RBUSY_BP;
    logic                CBUSY, CBUSY_BP;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .WE4(WE4), .A4(A4), .WD4(WD4),
        .RA(RA), .RD(RD), .RBUSY(RBUSY),
        .SB_SET(SB_SET), .SB_A(SB_A),
        .SCLR(SCLR), .CBUSY(CBUSY)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut_bp (
        .CLK(CLK), .CLR_N(CLR_N),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .WE4(WE4), .A4(A4), .WD4(WD4),
        .RA(RA), .RD(RD_BP), .RBUSY(RBUSY_BP),
        .SB_SET(SB_SET), .SB_A(SB_A),
        .SCLR(SCLR), .CBUSY(CBUSY_BP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_RD0:    return RD[31:0];
            SEL_RD1:    return RD[63:32];
            SEL_RB0:    return {31'b0, RBUSY[0]};
            SEL_RB1:    return {31'b0, RBUSY[1]};
            SEL_CBUSY:  return {31'b0, CBUSY};
            SEL_BP_RD0: return RD_BP[31:0];
            default:    return 'x;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so everything queued during a cycle
    // is compared at the falling edge, well clear of the rising edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, actual(mon_e.sel), mon_e.exp);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WE3 = 0; A3 = '0; WD3 = '0;
        WE4 = 0; A4 = '0; WD4 = '0;
        SB_SET = 0; SB_A = '0; SCLR = 0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RA = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLR_N = 0;
        idle_inputs();
        set_ra(5'd5, 5'd31);
        tick();
        tick();
        CLR_N = 1;

        // Reset state
        expect_val("reset_rd0",   SEL_RD0,   32'h0);
        expect_val("reset_rd1",   SEL_RD1,   32'h0);
        expect_val("reset_rb0",   SEL_RB0,   32'h0);
        expect_val("reset_rb1",   SEL_RB1,   32'h0);
        expect_val("reset_cbusy", SEL_CBUSY, 32'h0);
        tick();

        // Single write, registered vs bypassed visibility
        WE3 = 1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
        set_ra(5'd5, 5'd0);
        expect_val("nobp_same_cycle_old", SEL_RD0,    32'h0);
        expect_val("bp_same_cycle_new",   SEL_BP_RD0, 32'hDEADBEEF);
        tick();
        idle_inputs();
        expect_val("write5_next_cycle", SEL_RD0, 32'hDEADBEEF);
        tick();

        // Same-address collision: port 4 wins in storage and in bypass
        WE3 = 1; A3 = 5'd7; WD3 = 32'h11;
        WE4 = 1; A4 = 5'd7; WD4 = 32'h22;
        set_ra(5'd7, 5'd5);
        expect_val("bp_collision_p4", SEL_BP_RD0, 32'h22);
        tick();
        idle_inputs();
        expect_val("collision_stores_wd4", SEL_RD0, 32'h22);
        tick();

        // Write to register 0 is dropped
        WE3 = 1; A3 = 5'd0; WD3 = 32'hFF;
        set_ra(5'd0, 5'd0);
        expect_val("bp_reg0_zero", SEL_BP_RD0, 32'h0);
        tick();
        idle_inputs();
        expect_val("reg0_reads_zero", SEL_RD1, 32'h0);
        tick();

        // Two independent writes in one cycle
        WE3 = 1; A3 = 5'd8; WD3 = 32'h33;
        WE4 = 1; A4 = 5'd9; WD4 = 32'h44;
        tick();
        idle_inputs();
        set_ra(5'd8, 5'd9);
        expect_val("dual_write_p3", SEL_RD0, 32'h33);
        expect_val("dual_write_p4", SEL_RD1, 32'h44);
        tick();

        // Scoreboard set, release by write, set-over-release priority
        SB_SET = 1; SB_A = 5'd9;
        set_ra(5'd9, 5'd0);
        expect_val("sb_before_edge", SEL_RB0, 32'h0);
        tick();
        idle_inputs();
        WE3 = 1; A3 = 5'd9; WD3 = 32'h99;
        expect_val("sb_set_visible", SEL_RB0, 32'h1);
        tick();
        idle_inputs();
        expect_val("sb_released_by_write", SEL_RB0, 32'h0);
        expect_val("sb_release_data",      SEL_RD0, 32'h99);
        SB_SET = 1; SB_A = 5'd9;
        WE3 = 1; A3 = 5'd9; WD3 = 32'hAA;
        tick();
        idle_inputs();
        expect_val("sb_set_beats_write", SEL_RB0, 32'h1);
        expect_val("sb_set_write_data",  SEL_RD0, 32'hAA);
        SB_SET = 1; SB_A = 5'd0;
        tick();
        idle_inputs();
        expect_val("sb_reg0_never_busy", SEL_RB1, 32'h0);
        SB_SET = 1; SB_A = 5'd12;
        tick();
        idle_inputs();
        set_ra(5'd9, 5'd12);
        WE4 = 1; A4 = 5'd12; WD4 = 32'hC;
        expect_val("sb_set12", SEL_RB1, 32'h1);
        tick();
        idle_inputs();
        expect_val("sb_released_by_wd4", SEL_RB1, 32'h0);
        tick();

        // Fill every register, then reserve 9 and request the sweep together
        for (int i = 1; i < NREGS; i++) begin
            WE3 = 1; A3 = AW'(i); WD3 = 32'h1000_0000 + i;
            tick();
        end
        idle_inputs();
        SB_SET = 1; SB_A = 5'd9;
        SCLR = 1;
        expect_val("clear_cbusy_before", SEL_CBUSY, 32'h0);
        tick();
        idle_inputs();

        // Sweep: writes, reservations and repeated SCLR are all ignored
        for (int c = 0; c < NREGS; c++) begin
            WE3 = 1; A3 = 5'd1; WD3 = 32'hBAD;
            SB_SET = 1; SB_A = 5'd1;
            SCLR = (c < NREGS - 1);
            if (c == 0) set_ra(5'd0, 5'd9);
            else        set_ra(AW'(c), AW'(c - 1));
            expect_val($sformatf("clear_cbusy_c%0d", c), SEL_CBUSY, 32'h1);
            expect_val($sformatf("clear_pending_c%0d", c), SEL_RD0,
                       (c == 0) ? 32'h0 : 32'h1000_0000 + c);
            if (c == 0) begin
                expect_val("clear_c0_reg9", SEL_RD1, 32'h1000_0009);
                expect_val("clear_c0_busy9", SEL_RB1, 32'h1);
            end else begin
                expect_val($sformatf("clear_done_c%0d", c), SEL_RD1, 32'h0);
            end
            tick();
        end
        idle_inputs();
        set_ra(5'd1, 5'd9);
        expect_val("clear_cbusy_after",   SEL_CBUSY, 32'h0);
        expect_val("clear_we3_ignored",   SEL_RD0,   32'h0);
        expect_val("clear_set_ignored",   SEL_RB0,   32'h0);
        expect_val("clear_busy9_wiped",   SEL_RB1,   32'h0);
        expect_val("clear_reg9_zero",     SEL_RD1,   32'h0);
        tick();

        // Reset aborts an in-progress sweep
        WE3 = 1; A3 = 5'd3;  WD3 = 32'h33;
        WE4 = 1; A4 = 5'd20; WD4 = 32'h20;
        SB_SET = 1; SB_A = 5'd25;
        tick();
        idle_inputs();
        SCLR = 1;
        tick();
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        CLR_N = 0;
        expect_val("abort_cbusy_at_c10", SEL_CBUSY, 32'h1);
        tick();
        CLR_N = 1;
        set_ra(5'd20, 5'd25);
        expect_val("abort_cbusy_low", SEL_CBUSY, 32'h0);
        expect_val("abort_reg20_zero", SEL_RD0,  32'h0);
        expect_val("abort_busy25_zero", SEL_RB1, 32'h0);
        WE3 = 1; A3 = 5'd1; WD3 = 32'h77;
        tick();
        idle_inputs();
        SCLR = 1;
        set_ra(5'd1, 5'd3);
        expect_val("restart_reg1_written", SEL_RD0, 32'h77);
        expect_val("abort_reg3_zero",      SEL_RD1, 32'h0);
        tick();
        idle_inputs();
        expect_val("restart_c0_cbusy", SEL_CBUSY, 32'h1);
        expect_val("restart_c0_reg1",  SEL_RD0,   32'h77);
        tick();
        expect_val("restart_c1_reg1",  SEL_RD0,   32'h77);
        tick();
        expect_val("restart_c2_reg1",  SEL_RD0,   32'h0);
        tick();
        for (int c = 3; c < NREGS - 1; c++) tick();
        expect_val("restart_c31_cbusy", SEL_CBUSY, 32'h1);
        tick();
        expect_val("restart_end_cbusy", SEL_CBUSY, 32'h0);
        tick();
        tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
